// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for the EX-stage ALU: issue side and result side handshakes.
interface alu_exec_unit_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (output in_valid, alu_op, funct7, funct3, op_a, op_b, out_ready,
                  input  in_ready, out_valid, result, busy);
  modport slave  (input  in_valid, alu_op, funct7, funct3, op_a, op_b, out_ready,
                  output in_ready, out_valid, result, busy);
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: ALUOp/funct decode, single-cycle base ops, iterative shift-add
// multiply and restoring divide for the M extension, valid/ready on both sides.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter int SHAMT_W  = $clog2(XLEN)
) (
  input logic          clk,
  input logic          rst,
  alu_exec_unit_if.slave io
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state, state_d;
  logic [XLEN-1:0]   res_q, res_d, mcand_q, mcand_d, quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d, dvs_q, dvs_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d, negr_q, negr_d, sel_q, sel_d;

  logic              in_ready_w, accept, is_m, a_sgn, b_sgn, a_neg, b_neg, ovf;
  logic [3:0]        code;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]   base_res, mag_a, mag_b;
  logic [XLEN:0]     sum, sh, diff;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   quo_step, rem_step, q_fin, r_fin;

  assign in_ready_w   = (state == S_IDLE) || (state == S_DONE && io.out_ready);
  assign accept       = io.in_valid && in_ready_w;
  assign io.in_ready  = in_ready_w;
  assign io.out_valid = (state == S_DONE);
  assign io.busy      = (state == S_MUL) || (state == S_DIV);
  assign io.result    = res_q;

  assign is_m  = ENABLE_M && io.alu_op == 2'b10 && io.funct7 == 7'b0000001;
  assign shamt = io.op_b[SHAMT_W-1:0];

  // ALUOp 11 borrows funct7[5] only for funct3=101 so SRAI decodes while ADDI stays ADD.
  always_comb begin
    case (io.alu_op)
      2'b00:   code = 4'b0000;
      2'b01:   code = 4'b1000;
      2'b10:   code = {io.funct7[5], io.funct3};
      default: code = {(io.funct3 == 3'b101) && io.funct7[5], io.funct3};
    endcase
  end

  always_comb begin
    case (code)
      4'b1000: base_res = io.op_a - io.op_b;
      4'b0001: base_res = io.op_a << shamt;
      4'b0010: base_res = {{(XLEN-1){1'b0}}, $signed(io.op_a) < $signed(io.op_b)};
      4'b0011: base_res = {{(XLEN-1){1'b0}}, io.op_a < io.op_b};
      4'b0100: base_res = io.op_a ^ io.op_b;
      4'b0101: base_res = io.op_a >> shamt;
      4'b1101: base_res = $signed(io.op_a) >>> shamt;
      4'b0110: base_res = io.op_a | io.op_b;
      4'b0111: base_res = io.op_a & io.op_b;
      default: base_res = io.op_a + io.op_b;
    endcase
  end

  // Signedness per M op: MULH both, MULHSU a only, DIV/REM both, others unsigned.
  assign a_sgn = io.funct3[2] ? !io.funct3[0] : (io.funct3[1:0] == 2'b01 || io.funct3[1:0] == 2'b10);
  assign b_sgn = io.funct3[2] ? !io.funct3[0] : (io.funct3[1:0] == 2'b01);
  assign a_neg = a_sgn && io.op_a[XLEN-1];
  assign b_neg = b_sgn && io.op_b[XLEN-1];
  assign mag_a = a_neg ? -io.op_a : io.op_a;
  assign mag_b = b_neg ? -io.op_b : io.op_b;
  assign ovf   = !io.funct3[0] && io.op_a == {1'b1, {(XLEN-1){1'b0}}} && io.op_b == '1;

  assign sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
  assign acc_step = {sum, acc_q[XLEN-1:1]};
  assign prod     = neg_q ? -acc_step : acc_step;

  // Partial remainder stays below divisor, so the shifted value fits in XLEN+1 bits.
  assign sh       = {rem_q, quo_q[XLEN-1]};
  assign diff     = sh - {1'b0, dvs_q};
  assign rem_step = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_step = {quo_q[XLEN-2:0], !diff[XLEN]};
  assign q_fin    = neg_q  ? -quo_step : quo_step;
  assign r_fin    = negr_q ? -rem_step : rem_step;

  always_comb begin
    state_d = state;
    res_d   = res_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    sel_d   = sel_q;
    case (state)
      S_MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = sel_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = sel_q ? r_fin : q_fin;
          state_d = S_DONE;
        end
      end
      S_DONE: if (io.out_ready && !io.in_valid) state_d = S_IDLE;
      default: ;
    endcase
    if (accept) begin
      if (!is_m) begin
        res_d   = base_res;
        state_d = S_DONE;
      end else if (!io.funct3[2]) begin
        acc_d   = {{XLEN{1'b0}}, mag_b};
        mcand_d = mag_a;
        neg_d   = a_neg ^ b_neg;
        sel_d   = (io.funct3[1:0] != 2'b00);
        cnt_d   = CW'(XLEN);
        state_d = S_MUL;
      end else if (io.op_b == '0) begin
        res_d   = io.funct3[1] ? io.op_a : '1;
        state_d = S_DONE;
      end else if (ovf) begin
        res_d   = io.funct3[1] ? '0 : io.op_a;
        state_d = S_DONE;
      end else begin
        quo_d   = mag_a;
        rem_d   = '0;
        dvs_d   = mag_b;
        neg_d   = a_neg ^ b_neg;
        negr_d  = a_neg;
        sel_d   = io.funct3[1];
        cnt_d   = CW'(XLEN);
        state_d = S_DIV;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      res_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state   <= state_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      sel_q   <= sel_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: base decode, M-extension latency and edge cases, backpressure.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   lat, bcnt;

  alu_exec_unit_if #(.XLEN(32)) bus();

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (.clk(clk), .rst(rst), .io(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    bus.alu_op   = op;
    bus.funct7   = f7;
    bus.funct3   = f3;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_valid = 1'b1;
  endtask

  // Issue one op, then wait (bounded) for out_valid; returns latency and busy cycles.
  task automatic issue_wait(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b,
                            output int l, output int bc);
    drive(op, f7, f3, a, b);
    tick();
    bus.in_valid = 1'b0;
    bus.op_a = 32'h1234_5678;
    bus.op_b = 32'h0;
    bus.funct3 = 3'b000;
    l = 1;
    bc = 0;
    while (!bus.out_valid && l < 100) begin
      if (bus.busy) bc++;
      tick();
      l++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [6:0] f7,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int exp_lat);
    int l, bc;
    issue_wait(op, f7, f3, a, b, l, bc);
    chk({tag, "_res"}, bus.result, exp);
    chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
    tick();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.alu_op = 2'b00; bus.funct7 = 7'h0; bus.funct3 = 3'h0;
    bus.op_a = 32'h0; bus.op_b = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst0_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst0_in_ready",  32'(bus.in_ready),  32'd1);

    // Reset in the middle of a DIV
    drive(2'b10, 7'b0000001, 3'b100, 32'd100, 32'd3);
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    chk("div_busy_pre_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_result",    bus.result,          32'd0);
    chk("rst_busy",      32'(bus.busy),       32'd0);
    repeat (40) tick();
    chk("rst_no_late_valid", 32'(bus.out_valid), 32'd0);

    // Immediate shifts
    run("srai", 2'b11, 7'b0100000, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
    run("srli", 2'b11, 7'b0000000, 3'b101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);

    // Back-to-back ADD then SUB
    drive(2'b00, 7'h0, 3'h0, 32'd5, 32'd7);
    chk("b2b_rdy0", 32'(bus.in_ready), 32'd1);
    tick();
    chk("b2b_add_v", 32'(bus.out_valid), 32'd1);
    chk("b2b_add",   bus.result, 32'd12);
    drive(2'b01, 7'h0, 3'h0, 32'd5, 32'd7);
    chk("b2b_rdy1", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_sub_v", 32'(bus.out_valid), 32'd1);
    chk("b2b_sub",   bus.result, 32'hFFFF_FFFE);
    tick();

    // Base R-type ops
    run("slt",   2'b10, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run("sltu",  2'b10, 7'h00, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run("xor",   2'b10, 7'h00, 3'b100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1);
    run("and",   2'b10, 7'h00, 3'b111, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1);
    run("or",    2'b10, 7'h00, 3'b110, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1);
    run("sll",   2'b10, 7'h00, 3'b001, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1);
    run("sra",   2'b10, 7'h20, 3'b101, 32'h8000_0010, 32'd4, 32'hF800_0001, 1);
    run("sub_r", 2'b10, 7'h20, 3'b000, 32'd10, 32'd3, 32'd7, 1);
    run("bad_code_add", 2'b10, 7'h20, 3'b001, 32'd10, 32'd3, 32'd13, 1);
    run("addi_f7", 2'b11, 7'h20, 3'b000, 32'd10, 32'd3, 32'd13, 1);

    // Multiply
    issue_wait(2'b10, 7'b0000001, 3'b001, 32'hFFFF_FFFE, 32'd3, lat, bcnt);
    chk("mulh_res",  bus.result, 32'hFFFF_FFFF);
    chk("mulh_lat",  32'(lat),   32'd33);
    chk("mulh_busy", 32'(bcnt),  32'd32);
    tick();
    run("mul",    2'b10, 7'b0000001, 3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 33);
    run("mulhsu", 2'b10, 7'b0000001, 3'b010, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33);

    // Divide
    run("div",      2'b10, 7'b0000001, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run("rem",      2'b10, 7'b0000001, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run("divu",     2'b10, 7'b0000001, 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run("divu_z",   2'b10, 7'b0000001, 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    run("remu_z",   2'b10, 7'b0000001, 3'b111, 32'd100, 32'd0, 32'd100, 1);
    run("div_ovf",  2'b10, 7'b0000001, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",  2'b10, 7'b0000001, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Backpressure after MULHU
    bus.out_ready = 1'b0;
    issue_wait(2'b10, 7'b0000001, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    chk("mulhu_res", bus.result, 32'hFFFF_FFFE);
    chk("mulhu_lat", 32'(lat),   32'd33);
    drive(2'b00, 7'h0, 3'h0, 32'd1, 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_res",   bus.result,         32'hFFFF_FFFE);
      chk("bp_rdy",   32'(bus.in_ready),  32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rdy_rel", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_next_v",   32'(bus.out_valid), 32'd1);
    chk("bp_next_res", bus.result,         32'd3);
    tick();
    chk("idle_after", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
